// File: rtl/piece_mover.sv
// Active-piece engine: holds a BLOCKS-cell piece and performs collision-checked
// moves, rotation and gravity by probing the board one cell per cycle.
module piece_mover #(
  parameter int COLS        = 10,
  parameter int ROWS        = 20,
  parameter int XW          = 5,
  parameter int YW          = 6,
  parameter int BLOCKS      = 4,
  parameter int GRAVITY_DIV = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 spawn,
  input  logic [BLOCKS*XW-1:0] spawn_x,
  input  logic [BLOCKS*YW-1:0] spawn_y,
  input  logic                 cmd_left,
  input  logic                 cmd_right,
  input  logic                 cmd_down,
  input  logic                 cmd_rotate,
  output logic [XW-1:0]        query_x,
  output logic [YW-1:0]        query_y,
  input  logic                 query_occ,
  output logic [BLOCKS*XW-1:0] piece_x,
  output logic [BLOCKS*YW-1:0] piece_y,
  output logic                 cmd_ready,
  output logic                 lock_valid,
  output logic                 game_over
);

  localparam int IW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_COMMIT, S_READY, S_LOCK, S_OVER} state_t;
  typedef enum logic [1:0] {M_SPAWN, M_MOVE, M_DOWN} mode_t;
  typedef enum logic [2:0] {A_NONE, A_GRAV, A_ROT, A_LEFT, A_RIGHT, A_DOWN} act_t;

  state_t state, state_n;
  mode_t  mode;
  act_t   act;

  logic [IW-1:0]        idx;
  logic                 is_grav;
  logic [GW-1:0]        grav_cnt;
  logic                 grav_pending;
  logic                 grav_tick;
  logic                 grav_wrap;
  logic                 cell_fail;

  logic signed [XW:0]   cand_x [BLOCKS];
  logic signed [YW:0]   cand_y [BLOCKS];
  logic signed [XW:0]   new_x  [BLOCKS];
  logic signed [YW:0]   new_y  [BLOCKS];

  int xi, yi, pxi, pyi, nxi, nyi;

  function automatic logic cell_ok(input logic signed [XW:0] x, input logic signed [YW:0] y);
    return (int'(x) >= 0) && (int'(x) < COLS) && (int'(y) >= 0) && (int'(y) < ROWS);
  endfunction

  always_comb begin
    act = A_NONE;
    if (grav_pending)    act = A_GRAV;
    else if (cmd_rotate) act = A_ROT;
    else if (cmd_left)   act = A_LEFT;
    else if (cmd_right)  act = A_RIGHT;
    else if (cmd_down)   act = A_DOWN;

    // Candidate cells: spawn coordinates in IDLE, otherwise the selected move
    pxi = int'(piece_x[XW +: XW]);
    pyi = int'(piece_y[YW +: YW]);
    xi  = 0;
    yi  = 0;
    nxi = 0;
    nyi = 0;
    for (int i = 0; i < BLOCKS; i++) begin
      xi  = int'(piece_x[i*XW +: XW]);
      yi  = int'(piece_y[i*YW +: YW]);
      nxi = xi;
      nyi = yi;
      case (act)
        A_ROT: begin
          nxi = pxi - (yi - pyi);
          nyi = pyi + (xi - pxi);
        end
        A_LEFT:         nxi = xi - 1;
        A_RIGHT:        nxi = xi + 1;
        A_GRAV, A_DOWN: nyi = yi + 1;
        default: ;
      endcase
      if (state == S_IDLE) begin
        nxi = int'(spawn_x[i*XW +: XW]);
        nyi = int'(spawn_y[i*YW +: YW]);
      end
      new_x[i] = nxi[XW:0];
      new_y[i] = nyi[YW:0];
    end
  end

  always_comb begin
    state_n    = state;
    query_x    = '0;
    query_y    = '0;
    cmd_ready  = 1'b0;
    lock_valid = 1'b0;
    game_over  = 1'b0;
    cell_fail  = !cell_ok(cand_x[idx], cand_y[idx]) || query_occ;
    case (state)
      S_IDLE:   if (spawn) state_n = S_CHECK;
      S_READY: begin
        cmd_ready = 1'b1;
        if (act != A_NONE) state_n = S_CHECK;
      end
      S_CHECK: begin
        query_x = cand_x[idx][XW-1:0];
        query_y = cand_y[idx][YW-1:0];
        if (cell_fail) begin
          case (mode)
            M_MOVE:  state_n = S_READY;
            M_DOWN:  state_n = S_LOCK;
            default: state_n = S_OVER;
          endcase
        end else if (idx == IW'(BLOCKS - 1)) begin
          state_n = S_COMMIT;
        end
      end
      S_COMMIT: state_n = S_READY;
      S_LOCK: begin
        lock_valid = 1'b1;
        state_n    = S_IDLE;
      end
      S_OVER:   game_over = 1'b1;
      default:  state_n = S_IDLE;
    endcase
  end

  assign grav_tick = frame_tick && (state == S_READY || state == S_CHECK || state == S_COMMIT);
  assign grav_wrap = grav_cnt == GW'(GRAVITY_DIV - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mode         <= M_SPAWN;
      idx          <= '0;
      is_grav      <= 1'b0;
      grav_cnt     <= '0;
      grav_pending <= 1'b0;
      piece_x      <= '0;
      piece_y      <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (spawn) begin
          mode    <= M_SPAWN;
          is_grav <= 1'b0;
          idx     <= '0;
        end
        S_READY: if (act != A_NONE) begin
          mode    <= (act == A_GRAV || act == A_DOWN) ? M_DOWN : M_MOVE;
          is_grav <= (act == A_GRAV);
          idx     <= '0;
        end
        S_CHECK: if (!cell_fail) idx <= idx + 1'b1;
        S_COMMIT: begin
          for (int i = 0; i < BLOCKS; i++) begin
            piece_x[i*XW +: XW] <= cand_x[i][XW-1:0];
            piece_y[i*YW +: YW] <= cand_y[i][YW-1:0];
          end
        end
        default: ;
      endcase

      if (state == S_IDLE && spawn) grav_cnt <= '0;
      else if (grav_tick)           grav_cnt <= grav_wrap ? '0 : grav_cnt + 1'b1;

      // A fresh gravity event outranks clearing the one just consumed
      if (grav_tick && grav_wrap)                                grav_pending <= 1'b1;
      else if ((state == S_COMMIT && is_grav) || state == S_LOCK) grav_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_IDLE && spawn) || (state == S_READY && act != A_NONE)) begin
      for (int i = 0; i < BLOCKS; i++) begin
        cand_x[i] <= new_x[i];
        cand_y[i] <= new_y[i];
      end
    end
  end

endmodule
